// File: rtl/vga_overlay_engine.sv
// vga_overlay_engine: VGA scan-out with up to NUM_FIELDS digit sprites composited over a background image.
// Latency: counter -> memory addresses 1 pixel, -> colour/syncs 2 pixels (1 pixel = 4 clk); free-running, no backpressure.
// Optional feature macro OVERLAY_TRANSPARENCY_EN: sprite pixels equal to KEY_COLOR show the background instead.
module vga_overlay_engine #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          NUM_FIELDS = 5,
    parameter int          DIGIT_W    = 49,
    parameter int          DIGIT_H    = 50,
    parameter int          MAX_DIGIT  = 9,
    parameter int          BG_AW      = 19,
    parameter int          SPRITE_AW  = 15,
    parameter logic [11:0] KEY_COLOR  = 12'h0F0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_FIELDS*10-1:0] field_x,
    input  logic [NUM_FIELDS*9-1:0]  field_y,
    input  logic [NUM_FIELDS*4-1:0]  field_val,
    input  logic [NUM_FIELDS-1:0]    field_en,
    output logic [BG_AW-1:0]         bg_addr,
    input  logic [11:0]              bg_color,
    output logic [SPRITE_AW-1:0]     sprite_addr,
    input  logic [11:0]              sprite_color,
    output logic                     hSync,
    output logic                     vSync,
    output logic [3:0]               VGA_R,
    output logic [3:0]               VGA_G,
    output logic [3:0]               VGA_B,
    output logic                     frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] DW       = 11'(DIGIT_W);
    localparam logic [10:0] DH       = 11'(DIGIT_H);
    localparam logic [3:0]  MAXD     = 4'(MAX_DIGIT);

`ifdef OVERLAY_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    // divider and scan counters
    logic [1:0]  div_q, div_d;
    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        pix_en;
    logic        last_pix;

    // frame-stable copies of the field controls
    logic [NUM_FIELDS*10-1:0] sh_x_q, sh_x_d;
    logic [NUM_FIELDS*9-1:0]  sh_y_q, sh_y_d;
    logic [NUM_FIELDS*4-1:0]  sh_val_q, sh_val_d;
    logic [NUM_FIELDS-1:0]    sh_en_q, sh_en_d;
    logic                     frame_start_q, frame_start_d;

    // stage 1
    logic                 active_q, active_d;
    logic                 hit_q, hit_d;
    logic                 hs1_q, hs1_d;
    logic                 vs1_q, vs1_d;
    logic [BG_AW-1:0]     bg_addr_q, bg_addr_d;
    logic [SPRITE_AW-1:0] sprite_addr_q, sprite_addr_d;

    // stage 2
    logic        hs2_q, hs2_d;
    logic        vs2_q, vs2_d;
    logic [11:0] rgb_q, rgb_d;

    // winning-field search
    logic        sel_hit;
    logic [10:0] sel_dx, sel_dy;
    logic [3:0]  sel_val;
    logic [10:0] fx, fy;
    logic [3:0]  fval;

    assign pix_en   = (div_q == 2'd3);
    assign last_pix = (hcount_q == H_LAST) && (vcount_q == V_LAST);

    // Descending scan so the lowest-index hitting field is the last writer and wins.
    always_comb begin
        sel_hit = 1'b0;
        sel_dx  = '0;
        sel_dy  = '0;
        sel_val = '0;
        fx      = '0;
        fy      = '0;
        fval    = '0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            fx   = {1'b0, sh_x_q[10*i +: 10]};
            fy   = {2'b0, sh_y_q[9*i +: 9]};
            fval = sh_val_q[4*i +: 4];
            if (sh_en_q[i] && (fval <= MAXD) &&
                (hcount_q >= fx) && (hcount_q < fx + DW) &&
                (vcount_q >= fy) && (vcount_q < fy + DH)) begin
                sel_hit = 1'b1;
                sel_dx  = hcount_q - fx;
                sel_dy  = vcount_q - fy;
                sel_val = fval;
            end
        end
    end

    always_comb begin
        div_d         = div_q + 2'd1;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        sh_x_d        = sh_x_q;
        sh_y_d        = sh_y_q;
        sh_val_d      = sh_val_q;
        sh_en_d       = sh_en_q;
        frame_start_d = 1'b0;
        active_d      = active_q;
        hit_d         = hit_q;
        hs1_d         = hs1_q;
        vs1_d         = vs1_q;
        bg_addr_d     = bg_addr_q;
        sprite_addr_d = sprite_addr_q;
        hs2_d         = hs2_q;
        vs2_d         = vs2_q;
        rgb_d         = rgb_q;

        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
            end else begin
                hcount_d = hcount_q + 11'd1;
            end

            if (last_pix) begin
                sh_x_d        = field_x;
                sh_y_d        = field_y;
                sh_val_d      = field_val;
                sh_en_d       = field_en;
                frame_start_d = 1'b1;
            end

            active_d = (hcount_q < H_ACT) && (vcount_q < V_ACT);
            hit_d    = sel_hit;
            hs1_d    = !((hcount_q >= HS_START) && (hcount_q < HS_END));
            vs1_d    = !((vcount_q >= VS_START) && (vcount_q < VS_END));
            bg_addr_d = ((hcount_q < H_ACT) && (vcount_q < V_ACT)) ?
                        BG_AW'(hcount_q) + BG_AW'(H_ACTIVE) * BG_AW'(vcount_q) : '0;
            sprite_addr_d = sel_hit ?
                        SPRITE_AW'(sel_dx) + SPRITE_AW'(DIGIT_W) * SPRITE_AW'(sel_dy) +
                        SPRITE_AW'(DIGIT_W * DIGIT_H) * SPRITE_AW'(sel_val) : '0;

            // Memory data for the stage-1 addresses has had a full pixel (4 clk) to settle.
            hs2_d = hs1_q;
            vs2_d = vs1_q;
            if (!active_q) begin
                rgb_d = 12'h000;
            end else if (hit_q && !(TRANSP && (sprite_color == KEY_COLOR))) begin
                rgb_d = sprite_color;
            end else begin
                rgb_d = bg_color;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            sh_x_q        <= '0;
            sh_y_q        <= '0;
            sh_val_q      <= '0;
            sh_en_q       <= '0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
            hit_q         <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            bg_addr_q     <= '0;
            sprite_addr_q <= '0;
            hs2_q         <= 1'b1;
            vs2_q         <= 1'b1;
            rgb_q         <= '0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            sh_x_q        <= sh_x_d;
            sh_y_q        <= sh_y_d;
            sh_val_q      <= sh_val_d;
            sh_en_q       <= sh_en_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
            hit_q         <= hit_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            bg_addr_q     <= bg_addr_d;
            sprite_addr_q <= sprite_addr_d;
            hs2_q         <= hs2_d;
            vs2_q         <= vs2_d;
            rgb_q         <= rgb_d;
        end
    end

    assign bg_addr     = bg_addr_q;
    assign sprite_addr = sprite_addr_q;
    assign hSync       = hs2_q;
    assign vSync       = vs2_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_overlay_engine.sv
// Bench for vga_overlay_engine on a scaled-down raster so several whole frames fit in a short run.
module tb_vga_overlay_engine;

    localparam int HA = 40, HFP = 4, HS = 6, HBP = 6, HT = HA + HFP + HS + HBP;
    localparam int VA = 30, VFP = 2, VS = 2, VBP = 4, VT = VA + VFP + VS + VBP;
    localparam int NF = 3, DW = 7, DH = 6, MAXD = 9, BGAW = 11, SPAW = 9;
    localparam logic [11:0] KEY = 12'h0F0;
    localparam int FPIX = HT * VT;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NF*10-1:0]  field_x = '0;
    logic [NF*9-1:0]   field_y = '0;
    logic [NF*4-1:0]   field_val = '0;
    logic [NF-1:0]     field_en = '0;
    logic [BGAW-1:0]   bg_addr;
    logic [11:0]       bg_color = '0;
    logic [SPAW-1:0]   sprite_addr;
    logic [11:0]       sprite_color = '0;
    logic              hSync, vSync, frame_start;
    logic [3:0]        VGA_R, VGA_G, VGA_B;

    int n_cmp = 0;
    int n_fail = 0;

    vga_overlay_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .NUM_FIELDS(NF), .DIGIT_W(DW), .DIGIT_H(DH), .MAX_DIGIT(MAXD),
        .BG_AW(BGAW), .SPRITE_AW(SPAW), .KEY_COLOR(KEY)
    ) dut (
        .clk(clk), .reset(reset),
        .field_x(field_x), .field_y(field_y), .field_val(field_val), .field_en(field_en),
        .bg_addr(bg_addr), .bg_color(bg_color),
        .sprite_addr(sprite_addr), .sprite_color(sprite_color),
        .hSync(hSync), .vSync(vSync),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // External memory contents, deterministic per address.
    function automatic logic [11:0] bg_fn(input int a);
        return 12'(a) ^ 12'hA5C;
    endfunction

    function automatic logic [11:0] sp_fn(input int a);
        return (a % 5 == 0) ? KEY : (12'(a) ^ 12'h3C7);
    endfunction

    logic [11:0] bg_p1 = '0, sp_p1 = '0;
    always @(posedge clk) begin
        bg_p1        <= bg_fn(int'(bg_addr));
        bg_color     <= bg_p1;
        sp_p1        <= sp_fn(int'(sprite_addr));
        sprite_color <= sp_p1;
    end

    function automatic int digit_addr(input int x, input int y, input int fx, input int fy,
                                      input int val, input int w, input int h);
        return (x - fx) + w * (y - fy) + w * h * val;
    endfunction

    // Model time: e = clk edges since reset release, m = pixel steps taken.
    int e = 0;
    int m = 0;
    logic [NF*10-1:0] hx [0:15];
    logic [NF*9-1:0]  hy [0:15];
    logic [NF*4-1:0]  hv [0:15];
    logic [NF-1:0]    he [0:15];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e = 0;
            m = 0;
            for (int k = 0; k < 16; k++) begin
                hx[k] = '0; hy[k] = '0; hv[k] = '0; he[k] = '0;
            end
        end else begin
            e = e + 1;
            if (e % 4 == 0) begin
                m = m + 1;
                if (m % FPIX == 0 && m / FPIX < 16) begin
                    hx[m / FPIX] = field_x;
                    hy[m / FPIX] = field_y;
                    hv[m / FPIX] = field_val;
                    he[m / FPIX] = field_en;
                end
            end
        end
    end

    // What the raster must look like for the pixel scanned at step c.
    function automatic void model_pix(input int c, output int sa, output int ba,
                                      output logic hs, output logic vs, output logic [11:0] col);
        int h, v, f, fx, fy, fv;
        logic act, hit;
        h = c % HT;
        v = (c / HT) % VT;
        f = c / FPIX;
        if (f > 15) f = 15;
        act = (h < HA) && (v < VA);
        hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
        vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
        ba  = act ? h + HA * v : 0;
        hit = 1'b0;
        sa  = 0;
        for (int i = 0; i < NF; i++) begin
            fx = int'(hx[f][10*i +: 10]);
            fy = int'(hy[f][9*i +: 9]);
            fv = int'(hv[f][4*i +: 4]);
            if (!hit && he[f][i] && fv <= MAXD && h >= fx && h < fx + DW && v >= fy && v < fy + DH) begin
                hit = 1'b1;
                sa  = digit_addr(h, v, fx, fy, fv, DW, DH) % (1 << SPAW);
            end
        end
        if (!act) col = 12'h000;
        else if (!hit) col = bg_fn(ba);
`ifdef OVERLAY_TRANSPARENCY_EN
        else if (sp_fn(sa) == KEY) col = bg_fn(ba);
`endif
        else col = sp_fn(sa);
    endfunction

    always @(negedge clk) begin
        int sa_e, ba_e, sa2, ba2;
        logic hs_e, vs_e, hs_x, vs_x, fs_e;
        logic [11:0] col_e, col_x;
        logic [34:0] exp_v, got_v;
        sa_e = 0; ba_e = 0; hs_e = 1'b1; vs_e = 1'b1; col_e = 12'h000;
        if (m >= 1) model_pix(m - 1, sa_e, ba_e, hs_x, vs_x, col_x);
        if (m >= 2) model_pix(m - 2, sa2, ba2, hs_e, vs_e, col_e);
        fs_e  = (e > 0) && (e % 4 == 0) && ((e / 4) % FPIX == 0);
        exp_v = {hs_e, vs_e, col_e, 11'(ba_e), 9'(sa_e), fs_e};
        got_v = {hSync, vSync, VGA_R, VGA_G, VGA_B, bg_addr, sprite_addr, frame_start};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle step=%0d edge=%0d: got {hs,vs,rgb,bg,sp,fs}=%h required %h", m, e, got_v, exp_v);
        end
    end

    // Sync period/width and frame_start counting, in clk cycles.
    int cyc = 0, hs_fall = -1, vs_fall = -1, hs_period = 0, hs_low = 0, vs_period = 0, vs_low = 0, fs_cnt = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    always @(negedge clk) begin
        cyc++;
        if (hs_prev && !hSync) begin
            if (hs_fall >= 0) hs_period = cyc - hs_fall;
            hs_fall = cyc;
        end
        if (!hs_prev && hSync) hs_low = cyc - hs_fall;
        if (vs_prev && !vSync) begin
            if (vs_fall >= 0) vs_period = cyc - vs_fall;
            vs_fall = cyc;
        end
        if (!vs_prev && vSync) vs_low = cyc - vs_fall;
        if (frame_start) fs_cnt++;
        hs_prev = hSync;
        vs_prev = vSync;
    end

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, req, req);
        end
    endtask

    task automatic wait_m(input int target);
        int guard;
        guard = 0;
        while (m != target && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        if (m != target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_timeout: at pixel step %0d, required %0d", m, target);
        end
    endtask

    function automatic int px(input int f, input int x, input int y);
        return f * FPIX + y * HT + x;
    endfunction

    task automatic wait_addr(input int f, input int x, input int y);
        wait_m(px(f, x, y) + 1);
    endtask

    task automatic wait_out(input int f, input int x, input int y);
        wait_m(px(f, x, y) + 2);
    endtask

    function automatic int rgb();
        return int'({VGA_R, VGA_G, VGA_B});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full-size address examples pin the model's address rule.
        check("pin_addr_80_140", digit_addr(80, 140, 80, 140, 3, 49, 50), 7350);
        check("pin_addr_129_189", digit_addr(129, 189, 80, 140, 3, 49, 50), 9800);
        check("pin_base_val7", digit_addr(80, 140, 80, 140, 7, 49, 50), 17150);

        repeat (3) @(negedge clk);
        check("rst_hsync", int'(hSync), 1);
        check("rst_vsync", int'(vSync), 1);
        check("rst_rgb", rgb(), 0);
        check("rst_bg_addr", int'(bg_addr), 0);
        check("rst_sprite_addr", int'(sprite_addr), 0);
        check("rst_frame_start", int'(frame_start), 0);
        #2 reset = 1'b1;

        field_x   = {10'd25, 10'd14, 10'd10};
        field_y   = {9'd3, 9'd10, 9'd8};
        field_val = {4'd10, 4'd5, 4'd3};
        field_en  = 3'b111;

        wait_addr(0, 10, 8);
        check("f0_no_shadow_yet", int'(sprite_addr), 0);

        wait_addr(1, 0, 2);
        field_val[3:0] = 4'd7;

        wait_addr(1, 26, 4);
        check("val10_disabled_addr", int'(sprite_addr), 0);
        wait_out(1, 26, 4);
        check("val10_bg_colour", rgb(), 12'hAE6);
        wait_addr(1, 10, 8);
        check("hit_origin_addr", int'(sprite_addr), 126);
        wait_out(1, 10, 8);
        check("hit_origin_colour", rgb(), 12'h3B9);
        wait_addr(1, 14, 8);
        check("key_pixel_addr", int'(sprite_addr), 130);
        wait_out(1, 14, 8);
`ifdef OVERLAY_TRANSPARENCY_EN
        check("key_pixel_colour", rgb(), 12'hB12);
`else
        check("key_pixel_colour", rgb(), 12'h0F0);
`endif
        wait_addr(1, 17, 8);
        check("right_edge_miss_addr", int'(sprite_addr), 0);
        wait_out(1, 17, 8);
        check("right_edge_miss_colour", rgb(), 12'hB0D);
        wait_out(1, 45, 8);
        check("blanking_colour", rgb(), 0);
        wait_addr(1, 14, 10);
        check("overlap_field0_wins", int'(sprite_addr), 144);
        wait_addr(1, 16, 13);
        check("cell_corner_addr", int'(sprite_addr), 167);

        wait_addr(2, 10, 8);
        check("val7_after_frame_start", int'(sprite_addr), 294);
        wait_out(2, 10, 8);
        check("val7_colour", rgb(), 12'h2E1);
        check("hsync_period", hs_period, 4 * HT);
        check("hsync_low", hs_low, 4 * HS);
        check("vsync_period", vs_period, 4 * FPIX);
        check("vsync_low", vs_low, 4 * VS * HT);
        check("frame_start_count", fs_cnt, 2);

        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_rgb", rgb(), 0);
        check("midrst_sprite_addr", int'(sprite_addr), 0);
        check("midrst_bg_addr", int'(bg_addr), 0);
        check("midrst_hsync", int'(hSync), 1);
        repeat (5) @(negedge clk);
        field_val[3:0] = 4'd10;
        #2 reset = 1'b1;

        wait_addr(1, 10, 8);
        check("f0_val10_addr", int'(sprite_addr), 0);
        wait_addr(1, 14, 10);
        check("field1_origin_addr", int'(sprite_addr), 210);
        wait_out(1, 14, 10);
`ifdef OVERLAY_TRANSPARENCY_EN
        check("field1_key_colour", rgb(), 12'hBC2);
`else
        check("field1_key_colour", rgb(), 12'h0F0);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
